// File: rtl/flow_ctrl_unit.sv
// Program-flow sequencer: owns PC and status register, runs TRAP/NOP/JMP/JZ/JS/JZS/LSR/XSR.
// Latency: all effects 1 cycle after accept; op_ready low in TRAP/reset, source holds op. Option: FLOW_BRANCH_COUNT_EN.
module flow_ctrl_unit #(
  parameter int                ADDR_W      = 20,
  parameter logic [ADDR_W-1:0] RESET_PC    = 20'h00000,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 20'hFFF00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [ADDR_W-1:0] op_target,
  input  logic [3:0]        op_imm,
  input  logic              alu_valid,
  input  logic              alu_zero,
  input  logic              alu_sign,
  input  logic              alu_carry,
  output logic [ADDR_W-1:0] pc,
  output logic [3:0]        status,
  output logic              branch_taken,
  output logic              trap_active,
  input  logic              trap_ack
`ifdef FLOW_BRANCH_COUNT_EN
  ,
  output logic [15:0]       branch_count
`endif
);

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

  localparam logic [2:0] OP_TRAP = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_JZ   = 3'd3;
  localparam logic [2:0] OP_JS   = 3'd4;
  localparam logic [2:0] OP_JZS  = 3'd5;
  localparam logic [2:0] OP_LSR  = 3'd6;
  localparam logic [2:0] OP_XSR  = 3'd7;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, pc_inc, epc, epc_nxt;
  logic [3:0]        status_nxt;
  logic              branch_nxt;
  logic              accept;
  logic              cond;

  assign op_ready    = (state == RUN) && !rst;
  assign accept      = op_valid && op_ready;
  assign pc_inc      = pc + ADDR_W'(1);
  assign trap_active = (state == TRAP);

  // Branch conditions look only at the registered SR, never at same-cycle ALU flags.
  always_comb begin
    cond = 1'b0;
    case (op_code)
      OP_JMP:  cond = 1'b1;
      OP_JZ:   cond = status[0];
      OP_JS:   cond = status[1];
      OP_JZS:  cond = status[0] | status[1];
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    epc_nxt    = epc;
    status_nxt = status;
    branch_nxt = 1'b0;
    if (alu_valid)
      status_nxt[2:0] = {alu_carry, alu_sign, alu_zero};
    case (state)
      RUN: begin
        if (accept) begin
          case (op_code)
            OP_TRAP: begin
              epc_nxt   = pc_inc;
              pc_nxt    = TRAP_VECTOR;
              state_nxt = TRAP;
            end
            OP_JMP, OP_JZ, OP_JS, OP_JZS: begin
              if (cond) begin
                pc_nxt     = op_target;
                branch_nxt = 1'b1;
              end else begin
                pc_nxt = pc_inc;
              end
            end
            // SR writes override the ALU flag update on all four bits.
            OP_LSR: begin
              pc_nxt     = pc_inc;
              status_nxt = op_imm;
            end
            OP_XSR: begin
              pc_nxt     = pc_inc;
              status_nxt = status ^ op_imm;
            end
            default: pc_nxt = pc_inc;
          endcase
        end
      end
      TRAP: begin
        if (trap_ack) begin
          pc_nxt    = epc;
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pc           <= RESET_PC;
      epc          <= '0;
      status       <= 4'b0000;
      branch_taken <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      epc          <= epc_nxt;
      status       <= status_nxt;
      branch_taken <= branch_nxt;
    end
  end

`ifdef FLOW_BRANCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      branch_count <= 16'h0000;
    else if (branch_taken && (branch_count != 16'hFFFF))
      branch_count <= branch_count + 16'd1;
  end
`endif

endmodule
